// File: rtl/imem_pkg.sv
// imem_pkg: loader FSM states, NOP word and byte-lane ordering shared by the instruction memory
package imem_pkg;
    typedef enum logic [1:0] {CLEAR, IDLE, LOAD, DONE} ld_state_t;
    localparam logic [31:0] NOP = 32'h0000_0013;
    function automatic logic [7:0] lane(input logic [31:0] w, input int i, input bit big);
        return big ? w[8*(3-i) +: 8] : w[8*i +: 8];
    endfunction
endpackage

// File: rtl/imem_byte_array.sv
// imem_byte_array: byte storage with 4-byte write and combinational 4-byte read ports
// IMEM_PARITY_EN adds one even-parity bit per byte and a fetch parity check
module imem_byte_array import imem_pkg::*; #(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int MEM_DEPTH = 256,
    parameter bit BIG_ENDIAN = 1,
    localparam int MAW = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [MAW-1:0]        waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [MAW-1:0]        raddr,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  perr
);
    logic [BYTE_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic [BYTE_WIDTH-1:0] rb [4];
    always_ff @(posedge clk)
        if (we)
            for (int i = 0; i < 4; i++)
                mem_q[waddr + MAW'(i)] <= lane(wdata, i, BIG_ENDIAN);
    for (genvar g = 0; g < 4; g++) begin : g_rd
        assign rb[g] = mem_q[raddr + MAW'(g)];
    end
    assign rdata = BIG_ENDIAN ? {rb[0], rb[1], rb[2], rb[3]} : {rb[3], rb[2], rb[1], rb[0]};
`ifdef IMEM_PARITY_EN
    logic par_q [MEM_DEPTH];
    logic [3:0] pe;
    always_ff @(posedge clk)
        if (we)
            for (int i = 0; i < 4; i++)
                par_q[waddr + MAW'(i)] <= ^lane(wdata, i, BIG_ENDIAN);
    for (genvar g = 0; g < 4; g++) begin : g_par
        assign pe[g] = ^rb[g] ^ par_q[raddr + MAW'(g)];
    end
    assign perr = |pe;
`else
    assign perr = 1'b0;
`endif
endmodule

// File: rtl/imem_stream_loader.sv
// imem_stream_loader: instruction memory that zero-fills after reset and boot-loads an image from a FIFO
// IMEM_PARITY_EN enables per-byte parity and instr_perr; otherwise instr_perr is 0
module imem_stream_loader import imem_pkg::*; #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int MEM_DEPTH = 256,
    parameter bit BIG_ENDIAN = 1,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR = NOP,
    localparam int MAW = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] pc_addr,
    output logic [DATA_WIDTH-1:0] instr,
    output logic                  instr_misal,
    output logic                  instr_oob,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_valid,
    output logic                  fifo_ready,
    input  logic                  load_start,
    input  logic [MAW-1:0]        load_base,
    input  logic [MAW-1:0]        load_words,
    output logic                  load_busy,
    output logic                  prog_ready,
    output logic                  load_err,
    output logic                  instr_perr
);
    localparam logic [MAW:0] LAST = (MAW+1)'(MEM_DEPTH - 4);
    ld_state_t state_q, state_d;
    logic [MAW-1:0] clr_ptr_q, clr_ptr_d, remaining_q, remaining_d;
    logic [MAW:0] wr_ptr_q, wr_ptr_d;
    logic fifo_ready_q, fifo_ready_d, load_err_q, load_err_d;
    logic start, fire, oob_wr, we, perr;
    logic [MAW-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata, rdata;
    always_comb begin
        state_d = state_q;
        clr_ptr_d = clr_ptr_q;
        wr_ptr_d = wr_ptr_q;
        remaining_d = remaining_q;
        load_err_d = load_err_q;
        start = load_start && (state_q == IDLE || state_q == DONE);
        fire = state_q == LOAD && fifo_valid && fifo_ready_q;
        // wr_ptr carries an extra bit so running past the top is visible instead of wrapping
        oob_wr = wr_ptr_q > LAST;
        if (state_q == CLEAR) begin
            clr_ptr_d = clr_ptr_q + MAW'(4);
            state_d = clr_ptr_q == MAW'(MEM_DEPTH - 4) ? IDLE : CLEAR;
        end
        if (start) begin
            wr_ptr_d = {1'b0, load_base};
            remaining_d = load_words;
            load_err_d = |load_base[1:0];
            state_d = (|load_base[1:0] || load_words == '0) ? DONE : LOAD;
        end
        if (fire) begin
            wr_ptr_d = wr_ptr_q + (MAW+1)'(4);
            remaining_d = remaining_q - MAW'(1);
            load_err_d = load_err_q | oob_wr;
            state_d = (oob_wr || remaining_q == MAW'(1)) ? DONE : LOAD;
        end
        fifo_ready_d = state_d == LOAD;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            clr_ptr_q <= '0;
            wr_ptr_q <= '0;
            remaining_q <= '0;
            fifo_ready_q <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            clr_ptr_q <= clr_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            remaining_q <= remaining_d;
            fifo_ready_q <= fifo_ready_d;
            load_err_q <= load_err_d;
        end
    end
    assign we = state_q == CLEAR || (fire && !oob_wr);
    assign waddr = state_q == CLEAR ? clr_ptr_q : wr_ptr_q[MAW-1:0];
    assign wdata = state_q == CLEAR ? '0 : fifo_data;
    imem_byte_array #(
        .DATA_WIDTH(DATA_WIDTH),
        .BYTE_WIDTH(BYTE_WIDTH),
        .MEM_DEPTH(MEM_DEPTH),
        .BIG_ENDIAN(BIG_ENDIAN)
    ) u_arr (
        .clk(clk),
        .we(we),
        .waddr(waddr),
        .wdata(wdata),
        .raddr(pc_addr[MAW-1:0]),
        .rdata(rdata),
        .perr(perr)
    );
    assign prog_ready = state_q == DONE;
    assign load_busy = state_q == CLEAR || state_q == LOAD;
    assign fifo_ready = fifo_ready_q;
    assign load_err = load_err_q;
    assign instr = prog_ready ? rdata : NOP_INSTR;
    assign instr_perr = prog_ready & perr;
    assign instr_misal = |pc_addr[1:0];
    assign instr_oob = pc_addr > ADDR_WIDTH'(MEM_DEPTH - 4);
endmodule

// File: tb/tb_imem_stream_loader.sv
// tb_imem_stream_loader: randomized loads checked against a byte-array reference of the loader rules
module tb_imem_stream_loader;
    localparam logic [31:0] NOPW = 32'h0000_0013;
    logic clk = 0, rst = 1;
    logic [31:0] pc_addr = 0, instr, fifo_data = 0;
    logic instr_misal, instr_oob, fifo_valid = 0, fifo_ready;
    logic load_start = 0, load_busy, prog_ready, load_err, instr_perr;
    logic [7:0] load_base = 0, load_words = 0;
    logic [7:0] m [256];
    logic [31:0] q [$];
    int errors = 0, checks = 0;

    imem_stream_loader dut (
        .clk(clk), .rst(rst), .pc_addr(pc_addr), .instr(instr), .instr_misal(instr_misal),
        .instr_oob(instr_oob), .fifo_data(fifo_data), .fifo_valid(fifo_valid), .fifo_ready(fifo_ready),
        .load_start(load_start), .load_base(load_base), .load_words(load_words), .load_busy(load_busy),
        .prog_ready(prog_ready), .load_err(load_err), .instr_perr(instr_perr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mword(input int a);
        return {m[a % 256], m[(a + 1) % 256], m[(a + 2) % 256], m[(a + 3) % 256]};
    endfunction

    task automatic clear_check(input string tag);
        int bad = 0;
        @(negedge clk) rst = 1;
        fifo_valid = 0;
        load_start = 0;
        @(negedge clk) rst = 0;
        chk({tag, "_fifo_ready"}, fifo_ready, 0);
        chk({tag, "_load_err"}, load_err, 0);
        for (int i = 0; i < 64; i++) begin
            if (!load_busy || prog_ready || instr !== NOPW) bad++;
            @(negedge clk);
        end
        chk({tag, "_clear_window"}, bad, 0);
        chk({tag, "_idle_busy"}, load_busy, 0);
        chk({tag, "_idle_ready"}, prog_ready, 0);
        for (int i = 0; i < 256; i++) m[i] = 8'h00;
    endtask

    task automatic verify_mem(input string tag);
        int bad = 0;
        for (int a = 0; a < 256; a += 4) begin
            pc_addr = a;
            #1;
            if (instr !== mword(a)) begin
                bad++;
                $display("FAIL %s_word@%0h got=%h exp=%h", tag, a, instr, mword(a));
            end
        end
        chk({tag, "_mem_words_bad"}, bad, 0);
        for (int k = 0; k < 6; k++) begin
            pc_addr = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 255);
            #1;
            chk({tag, "_rnd_instr"}, instr, mword(int'(pc_addr[7:0])));
            chk({tag, "_rnd_misal"}, instr_misal, pc_addr[1:0] != 0);
            chk({tag, "_rnd_oob"}, instr_oob, pc_addr > 252);
            chk({tag, "_rnd_perr"}, instr_perr, 0);
        end
    endtask

    // q holds the image words on entry; mode 1 toggles fifo_valid every other cycle
    task automatic run_load(input string tag, input int base, input int n, input bit mode);
        logic [31:0] w [$];
        int exp_pops = 0, pops = 0, a;
        bit exp_err, fire;
        w = q;
        exp_err = base % 4 != 0;
        if (!exp_err)
            for (int k = 0; k < n; k++) begin
                a = base + 4 * k;
                exp_pops++;
                if (a > 252) begin
                    exp_err = 1;
                    break;
                end
                for (int i = 0; i < 4; i++) m[a + i] = w[k][31 - 8 * i -: 8];
            end
        @(negedge clk);
        load_base = 8'(base);
        load_words = 8'(n);
        load_start = 1;
        @(negedge clk) load_start = 0;
        if (n > 0 && base % 4 == 0) chk({tag, "_nop_loading"}, instr, NOPW);
        for (int c = 0; c < 3000 && load_busy; c++) begin
            fifo_valid = q.size() > 0 && (mode ? c % 2 == 0 : $urandom_range(0, 3) != 0);
            fifo_data = q.size() > 0 ? q[0] : $urandom;
            fire = fifo_valid && fifo_ready;
            @(posedge clk);
            if (fire) begin
                void'(q.pop_front());
                pops++;
            end
            @(negedge clk);
        end
        fifo_valid = 0;
        q.delete();
        chk({tag, "_timeout_busy"}, load_busy, 0);
        chk({tag, "_pops"}, pops, exp_pops);
        chk({tag, "_load_err"}, load_err, exp_err);
        chk({tag, "_prog_ready"}, prog_ready, 1);
        chk({tag, "_fifo_ready"}, fifo_ready, 0);
        verify_mem(tag);
    endtask

    initial begin
        clear_check("t1");
        run_load("t1_zero", 0, 0, 0);

        q = '{32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC};
        run_load("t2", 0, 3, 0);
        pc_addr = 4;
        #1;
        chk("t2_pc4", instr, 32'h5566_7788);
        chk("t2_mem4", instr[31:24], 8'h55);

        for (int k = 0; k < 4; k++) q.push_back($urandom);
        q.push_back($urandom);
        run_load("t3", 32, 4, 1);

        for (int k = 0; k < 4; k++) q.push_back($urandom);
        run_load("t4", 8'hF8, 4, 0);

        q.push_back($urandom);
        run_load("misal", 6, 3, 0);

        for (int r = 0; r < 4; r++) begin
            int n = $urandom_range(1, 24);
            for (int k = 0; k < n + 2; k++) q.push_back($urandom);
            run_load("rnd", 4 * $urandom_range(0, 63), n, r[0]);
        end

        // reset after two of five words have been popped
        @(negedge clk);
        load_base = 0;
        load_words = 5;
        load_start = 1;
        @(negedge clk) load_start = 0;
        for (int k = 0; k < 2; k++) begin
            fifo_valid = 1;
            fifo_data = $urandom | 32'h0101_0101;
            @(negedge clk);
        end
        fifo_valid = 0;
        chk("t5_busy_before_rst", load_busy, 1);
        clear_check("t5");
        run_load("t5_zero", 0, 0, 0);

`ifdef IMEM_PARITY_EN
        begin
            logic pb;
            for (int k = 0; k < 4; k++) q.push_back($urandom);
            run_load("t6", 0, 4, 0);
            pb = dut.u_arr.par_q[9];
            force dut.u_arr.par_q[9] = ~pb;
            for (int a = 0; a < 16; a += 4) begin
                pc_addr = a;
                #1;
                chk("t6_perr", instr_perr, a == 8);
            end
            release dut.u_arr.par_q[9];
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
